// File: rtl/regfile_sequencer_if.sv
// ============================================================================
// Module      : regfile_sequencer_if
// Description : Instruction handshake, register-file bus and status signals
//               between the sequencer and its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_sequencer_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       rf_addr;
    logic [DATA_W-1:0] rf_w_in;
    logic              rf_w_en;
    logic [DATA_W-1:0] rf_op0;
    logic [DATA_W-1:0] rf_op1;
    logic              done;
    logic              illegal;
    logic              flag_z;
    logic              flag_c;

    // Sequencer side: consumes instructions and read data, drives the register file.
    modport master (
        input  instr, instr_valid, rf_op0, rf_op1,
        output instr_ready, rf_addr, rf_w_in, rf_w_en, done, illegal, flag_z, flag_c
    );

    // Environment side: instruction source plus register file.
    modport slave (
        output instr, instr_valid, rf_op0, rf_op1,
        input  instr_ready, rf_addr, rf_w_in, rf_w_en, done, illegal, flag_z, flag_c
    );
endinterface

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
// Module      : regfile_sequencer
// Description : Accepts one instruction at a time, reads two operands from the
//               8x16 register file, executes a small ALU op and writes back.
//               Fixed four-cycle flow IDLE -> READ -> EXEC -> WB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer #(
    parameter int DATA_W     = 16,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  wire logic           clk,
    input  wire logic           reset,
    regfile_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [3:0] c_op_add = 4'd1;
    localparam logic [3:0] c_op_sub = 4'd2;
    localparam logic [3:0] c_op_and = 4'd3;
    localparam logic [3:0] c_op_or  = 4'd4;
    localparam logic [3:0] c_op_xor = 4'd5;
    localparam logic [3:0] c_op_mov = 4'd6;
    localparam logic [3:0] c_op_ldi = 4'd7;
    localparam logic [3:0] c_op_shl = 4'd8;
    localparam logic [3:0] c_op_shr = 4'd9;

    state_t            r_state;
    state_t            w_next_state;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_op0;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_result;
    logic              r_flag_z;
    logic              r_flag_c;

    logic [3:0]        w_opcode;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_writes;
    logic              w_updates_c;
    logic              w_carry;
    logic              w_illegal_op;
    logic              w_handshake;
    logic              w_rd_is_r0;

    assign w_opcode    = r_instr[15:12];
    assign w_handshake = (r_state == ST_IDLE) && bus.instr_valid;
    assign w_rd_is_r0  = (r_instr[11:9] == 3'd0);

    // State register; reset forces an immediate return to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/write-back strobes.
    always_comb begin
        w_next_state    = r_state;
        bus.instr_ready = 1'b0;
        bus.rf_w_en     = 1'b0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    w_next_state = ST_READ;
                end
            end
            ST_READ: w_next_state = ST_EXEC;
            ST_EXEC: w_next_state = ST_WB;
            ST_WB: begin
                bus.done     = 1'b1;
                bus.illegal  = w_illegal_op;
                bus.rf_w_en  = w_writes && !(PROTECT_R0 && w_rd_is_r0);
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ALU: result, carry/borrow and opcode class from the captured operands.
    always_comb begin
        w_sum        = {1'b0, r_op0} + {1'b0, r_op1};
        w_diff       = {1'b0, r_op0} - {1'b0, r_op1};
        w_result     = '0;
        w_writes     = 1'b1;
        w_updates_c  = 1'b0;
        w_carry      = 1'b0;
        w_illegal_op = 1'b0;
        case (w_opcode)
            c_op_add: begin
                w_result    = w_sum[DATA_W-1:0];
                w_carry     = w_sum[DATA_W];
                w_updates_c = 1'b1;
            end
            c_op_sub: begin
                // The extra top bit of the widened difference is the borrow.
                w_result    = w_diff[DATA_W-1:0];
                w_carry     = w_diff[DATA_W];
                w_updates_c = 1'b1;
            end
            c_op_and: w_result = r_op0 & r_op1;
            c_op_or:  w_result = r_op0 | r_op1;
            c_op_xor: w_result = r_op0 ^ r_op1;
            c_op_mov: w_result = r_op0;
            c_op_ldi: w_result = {{(DATA_W-9){1'b0}}, r_instr[8:0]};
            c_op_shl: w_result = r_op0 << r_instr[2:0];
            c_op_shr: w_result = r_op0 >> r_instr[2:0];
            4'd0:     w_writes = 1'b0;
            default: begin
                w_writes     = 1'b0;
                w_illegal_op = 1'b1;
            end
        endcase
    end

    // Datapath registers: instruction latch, operand capture, result and flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= '0;
            r_op0    <= '0;
            r_op1    <= '0;
            r_result <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_instr <= bus.instr;
            end
            // Operands are taken before write-back, so rd==rs sees the old value.
            if (r_state == ST_READ) begin
                r_op0 <= bus.rf_op0;
                r_op1 <= bus.rf_op1;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_result;
                // Zero flag follows every writing opcode, even a suppressed r0 write.
                if (w_writes) begin
                    r_flag_z <= (w_result == '0);
                end
                if (w_updates_c) begin
                    r_flag_c <= w_carry;
                end
            end
        end
    end

    assign bus.rf_addr = (r_state == ST_IDLE) ? 16'd0 : {4'd0, r_instr[11:3], 3'd0};
    assign bus.rf_w_in = r_result;
    assign bus.flag_z  = r_flag_z;
    assign bus.flag_c  = r_flag_c;

endmodule

`default_nettype wire

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Drives the write/read interface of the 8x16-bit register file and decodes the instruction word.
- Accepts one 16-bit instruction through a valid/ready handshake, presents the rd/rs0/rs1 fields on the register-file address bus and captures both read operands.
- Executes a small ALU operation, then issues a single-cycle write-back of the result.
- Sits between the instruction source and the register file; owns the regfile w_en, w_in and address inputs.

Parameters:
- DATA_W, 16, operand/result width; must match the register file.
- PROTECT_R0, 0, when 1, write-backs with rd=0 are suppressed (no rf_w_en pulse, done still pulses).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- instr  input  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs0, [5:3] rs1, [2:0] imm3.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block can accept an instruction; high only in IDLE.
- rf_addr  output  16  register-file address bus: [11:9] write select, [8:6] / [5:3] read selects; other bits 0.
- rf_w_in  output  DATA_W  write-back data.
- rf_w_en  output  1  write enable, one-cycle pulse.
- rf_op0  input  DATA_W  register-file read port 0 (combinational from rf_addr[8:6]).
- rf_op1  input  DATA_W  register-file read port 1 (combinational from rf_addr[5:3]).
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse, coincident with done, for an undefined opcode.
- flag_z  output  1  result of last writing instruction was zero.
- flag_c  output  1  carry/borrow of last ADD/SUB.

Behaviour:
- Interface is decided as: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values: all outputs 0 except instr_ready=1; state IDLE. All internal registers clear.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. Every instruction takes exactly 4 cycles; no pipelining.
- IDLE:
  - instr_ready=1 and rf_addr=0.
  - On instr_valid & instr_ready at a rising edge, latch instr and go to READ.
  - Without instr_valid, stay in IDLE.
- READ:
  - rf_addr[11:3] = latched instr[11:3] (held through EXEC and WB).
  - At the edge ending READ, capture rf_op0/rf_op1 into operand registers.
- EXEC: compute the result from the captured operands into a result register; update flags at the edge ending EXEC.
- WB:
  - rf_w_in = result.
  - rf_w_en=1 for writing opcodes, unless PROTECT_R0=1 and rd=0.
  - done=1 in every case.
  - Next state is IDLE; rf_w_en and done are low in every other state.
- Opcodes (arithmetic modulo 2^DATA_W):
  - 0 NOP: no write.
  - 1 ADD: op0+op1, flag_c = carry-out.
  - 2 SUB: op0-op1, flag_c = 1 iff op0<op1 unsigned.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 MOV: rd <= op0.
  - 7 LDI: rd <= zero-extended instr[8:0].
  - 8 SHL: op0 << imm3.
  - 9 SHR: op0 >> imm3, logical.
  - 10-15: illegal. No write, illegal=1 in WB, flags unchanged.
- Flags:
  - flag_z updated for every writing opcode, including a write suppressed by PROTECT_R0.
  - flag_c updated only by ADD/SUB.
  - Both hold otherwise.
- rd equal to rs0 or rs1: operands are captured in READ, before the write-back, so the old values are used.
- instr_valid while busy: ignored. The source must hold instr/instr_valid until the handshake; no buffering.
- Reset mid-operation: immediate return to IDLE, no rf_w_en pulse, no done, flags cleared.

Test Plan:
- Reset then LDI r1,0x0FF (instr=0x72FF) -> 4 cycles after handshake: rf_w_en=1, rf_addr[11:9]=1, rf_w_in=0x00FF, done=1, flag_z=0.
- r1=0xFFFF, r2=0x0001, ADD r3,r1,r2 (instr=0x1650) -> rf_w_in=0x0000, flag_z=1, flag_c=1; SUB r4,r2,r1 -> 0x0002, flag_c=1.
- Back-to-back valid held high for 3 instructions -> instr_ready high only every 4th cycle; exactly 3 done pulses in 12 cycles.
- Opcode 0xB -> illegal=1 and done=1 in WB, rf_w_en=0, flags unchanged; NOP -> done only.
- PROTECT_R0=1, LDI r0,5 -> no rf_w_en, done=1, flag_z=0; PROTECT_R0=0 -> write occurs.
- Assert reset during EXEC of ADD -> next cycle IDLE, instr_ready=1, no rf_w_en/done ever for that instruction, flags=0.
